// File: rtl/led_pkg.sv
// led_pkg: mode encoding shared by the LED pattern generator and its users.
package led_pkg;
   localparam int MODE_W = 3;
   localparam logic [MODE_W-1:0] MODE_SHIFT_L = 3'd0;
   localparam logic [MODE_W-1:0] MODE_SHIFT_R = 3'd1;
   localparam logic [MODE_W-1:0] MODE_BOUNCE  = 3'd2;
   localparam logic [MODE_W-1:0] MODE_COUNT   = 3'd3;
   localparam logic [MODE_W-1:0] MODE_BLINK   = 3'd4;
   localparam logic [MODE_W-1:0] MODE_FILL    = 3'd5;
   localparam logic [MODE_W-1:0] MODE_OFF     = 3'd6;
endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: divides clk into a one-cycle tick every DECIMATION enabled cycles.
module led_prescaler #(
   parameter int CNT_W = 20,
   parameter int unsigned DECIMATION = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIMATION - 1);
   logic [CNT_W-1:0] cnt;
   assign tick = en && (cnt == LAST);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt <= '0;
      else if (en) cnt <= tick ? '0 : cnt + CNT_W'(1);
   end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: N_LED running-light driver with six patterns, tick-aligned
// mode switching and PWM dimming of the registered output.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int N_LED = 10,
   parameter int CNT_W = 20,
   parameter int unsigned DECIMATION = 1000000,
   parameter int PWM_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic              mode_req,
   input  logic [PWM_W-1:0]  duty,
   output logic [N_LED-1:0]  runled,
   output logic              tick,
   output logic [MODE_W-1:0] mode_cur
);
   logic [N_LED-1:0] pattern, step_val, shifted;
   logic [MODE_W-1:0] pending_mode, apply_mode;
   logic [PWM_W-1:0] pwm_cnt;
   logic dir_up, pending, apply_pending, pwm_on;

   function automatic logic [N_LED-1:0] init_of(input logic [MODE_W-1:0] m);
      case (m)
         MODE_SHIFT_L, MODE_BOUNCE, MODE_FILL: init_of = N_LED'(1);
         MODE_SHIFT_R: init_of = {1'b1, {(N_LED-1){1'b0}}};
         MODE_BLINK:   init_of = '1;
         default:      init_of = '0;
      endcase
   endfunction

   led_prescaler #(.CNT_W(CNT_W), .DECIMATION(DECIMATION)) u_prescaler (
      .clk(clk), .reset(reset), .en(en), .tick(tick)
   );

   // a strobe landing on the tick edge is applied immediately
   assign apply_pending = pending | mode_req;
   assign apply_mode = mode_req ? mode : pending_mode;
   assign shifted = dir_up ? pattern << 1 : pattern >> 1;
   assign pwm_on = (&duty) | (pwm_cnt < duty);

   always_comb begin
      case (mode_cur)
         MODE_SHIFT_L: step_val = {pattern[N_LED-2:0], pattern[N_LED-1]};
         MODE_SHIFT_R: step_val = {pattern[0], pattern[N_LED-1:1]};
         MODE_BOUNCE:  step_val = shifted;
         MODE_COUNT:   step_val = pattern + N_LED'(1);
         MODE_BLINK:   step_val = ~pattern;
         MODE_FILL:    step_val = (&pattern) ? '0 : {pattern[N_LED-2:0], 1'b1};
         default:      step_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pattern      <= N_LED'(1);
         dir_up       <= 1'b1;
         mode_cur     <= MODE_SHIFT_L;
         pending      <= 1'b0;
         pending_mode <= MODE_SHIFT_L;
      end else if (tick && apply_pending) begin
         mode_cur <= apply_mode;
         pattern  <= init_of(apply_mode);
         dir_up   <= 1'b1;
         pending  <= 1'b0;
      end else begin
         if (mode_req) begin
            pending      <= 1'b1;
            pending_mode <= mode;
         end
         if (tick) begin
            pattern <= step_val;
            // turn around on reaching either end so end bits are shown once
            if (mode_cur == MODE_BOUNCE)
               dir_up <= shifted[N_LED-1] ? 1'b0 : shifted[0] ? 1'b1 : dir_up;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwm_cnt <= '0;
         runled  <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
         runled  <= pattern & {N_LED{pwm_on}};
      end
   end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: table-driven pattern checks with a tick-aligned scoreboard,
// plus hand-written sequences for strobe timing, PWM, freeze and async reset.
module tb_led_pattern_gen;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic en = 1'b1;
   logic mode_req = 1'b0;
   logic [2:0] mode = 3'd0;
   logic [3:0] duty = 4'hf;
   logic [3:0] runled;
   logic tick;
   logic [2:0] mode_cur;
   int tests = 0;
   int fails = 0;

   typedef struct {logic req; logic [2:0] mode; logic [3:0] led; logic [2:0] cur;} vec_t;
   typedef struct {logic [3:0] led; logic [2:0] cur;} exp_t;
   vec_t vecs[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   led_pattern_gen #(.N_LED(4), .CNT_W(2), .DECIMATION(4), .PWM_W(4)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .mode_req(mode_req),
      .duty(duty), .runled(runled), .tick(tick), .mode_cur(mode_cur)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic req, input logic [2:0] m, input logic [3:0] led, input logic [2:0] cur);
      vec_t v;
      v.req = req; v.mode = m; v.led = led; v.cur = cur;
      vecs.push_back(v);
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      while (tick !== 1'b1 && n < 16) begin
         step();
         n++;
      end
      if (tick !== 1'b1) check("tick_timeout", 0, 1);
   endtask

   task automatic strobe(input logic [2:0] m);
      mode = m;
      mode_req = 1'b1;
      step();
      mode_req = 1'b0;
   endtask

   // wait for a tick, queue the expectation, check it when runled catches up
   task automatic apply(input string name, input logic [3:0] led, input logic [2:0] cur, input int gap);
      int n;
      exp_t e;
      wait_tick(n);
      if (gap >= 0) check({name, "_period"}, n, gap);
      e.led = led; e.cur = cur;
      sb.push_back(e);
      step();
      check({name, "_tick_pulse"}, tick, 0);
      check({name, "_mode_cur"}, mode_cur, sb[0].cur);
      step();
      e = sb.pop_front();
      check({name, "_runled"}, runled, e.led);
   endtask

   initial begin
      int n, c;
      add(0, 0, 4'b0010, 0); add(0, 0, 4'b0100, 0); add(0, 0, 4'b1000, 0); add(0, 0, 4'b0001, 0);
      add(1, 2, 4'b0001, 2); add(0, 2, 4'b0010, 2); add(0, 2, 4'b0100, 2); add(0, 2, 4'b1000, 2);
      add(0, 2, 4'b0100, 2); add(0, 2, 4'b0010, 2); add(0, 2, 4'b0001, 2); add(0, 2, 4'b0010, 2);
      add(1, 5, 4'b0001, 5); add(0, 5, 4'b0011, 5); add(0, 5, 4'b0111, 5); add(0, 5, 4'b1111, 5);
      add(0, 5, 4'b0000, 5); add(0, 5, 4'b0001, 5);
      add(1, 3, 4'b0000, 3);
      for (int i = 1; i <= 16; i++) add(0, 3, 4'(i), 3);
      add(1, 1, 4'b1000, 1); add(0, 1, 4'b0100, 1); add(0, 1, 4'b0010, 1); add(0, 1, 4'b0001, 1);
      add(0, 1, 4'b1000, 1);
      add(1, 6, 4'b0000, 6); add(0, 6, 4'b0000, 6); add(1, 7, 4'b0000, 7); add(0, 7, 4'b0000, 7);
      add(1, 0, 4'b0001, 0); add(0, 0, 4'b0010, 0);

      repeat (3) step();
      check("rst_runled", runled, 0);
      check("rst_tick", tick, 0);
      check("rst_mode_cur", mode_cur, 0);
      reset = 1'b1;
      step();
      check("init_runled", runled, 4'b0001);
      check("init_mode_cur", mode_cur, 0);
      wait_tick(n);
      check("first_tick_delay", n, 2);

      foreach (vecs[i]) begin
         if (vecs[i].req) strobe(vecs[i].mode);
         apply("table", vecs[i].led, vecs[i].cur, i == 0 ? 0 : (vecs[i].req ? 1 : 2));
      end

      wait_tick(n);
      mode = 3'd4;
      mode_req = 1'b1;
      step();
      mode_req = 1'b0;
      check("coincident_mode_cur", mode_cur, 4);
      step();
      check("coincident_runled", runled, 4'b1111);
      apply("blink", 4'b0000, 4, 2);

      strobe(3'd1);
      strobe(3'd3);
      apply("double_req", 4'b0000, 3, 0);

      strobe(3'd0);
      apply("back_shl", 4'b0001, 0, 1);
      duty = 4'd4;
      step();
      for (int w = 0; w < 2; w++) begin
         c = 0;
         repeat (16) begin
            if (runled != 4'b0000) c++;
            step();
         end
         check("pwm_duty4_window", c, 4);
      end
      duty = 4'd0;
      step();
      c = 0;
      repeat (16) begin
         if (runled != 4'b0000) c++;
         step();
      end
      check("pwm_duty0", c, 0);
      duty = 4'hf;
      step();
      c = 0;
      repeat (16) begin
         if (runled != 4'b0000) c++;
         step();
      end
      check("pwm_duty15", c, 16);

      strobe(3'd2);
      apply("bounce_again", 4'b0001, 2, -1);
      apply("bounce_step", 4'b0010, 2, 2);
      en = 1'b0;
      repeat (10) begin
         step();
         check("freeze_tick", tick, 0);
         check("freeze_runled", runled, 4'b0010);
      end
      en = 1'b1;
      apply("unfreeze", 4'b0100, 2, 2);

      #2;
      reset = 1'b0;
      #1;
      check("async_rst_runled", runled, 0);
      check("async_rst_mode_cur", mode_cur, 0);
      check("async_rst_tick", tick, 0);
      step();
      reset = 1'b1;
      step();
      check("restart_runled", runled, 4'b0001);
      apply("restart", 4'b0010, 0, 2);

      en = 1'b0;
      strobe(3'd5);
      repeat (5) step();
      check("frozen_req_mode_cur", mode_cur, 0);
      check("frozen_req_runled", runled, 4'b0010);
      en = 1'b1;
      apply("frozen_req", 4'b0001, 5, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
